// File: rtl/mcu51_seq_pkg.sv
// Shared timing constants, encodings and helpers for the MCU51 machine-cycle sequencer.
package mcu51_seq_pkg;

    localparam int TICKS_PER_MC = 12;
    localparam int MAX_MC       = 4;

    localparam logic [3:0] T_SLOT_B = 4'd6;
    localparam logic [3:0] T_ALE_A  = 4'd1;
    localparam logic [3:0] T_PSEN_A = 4'd3;
    localparam logic [3:0] T_CS_A   = 4'd4;
    localparam logic [3:0] T_LAT_A  = 4'd5;
    localparam logic [3:0] T_ALE_B  = 4'd7;
    localparam logic [3:0] T_PSEN_B = 4'd9;
    localparam logic [3:0] T_CS_B   = 4'd10;
    localparam logic [3:0] T_LAT_B  = 4'd11;
    localparam logic [3:0] T_WB     = 4'd10;
    localparam logic [3:0] T_LAST   = 4'd11;

    // inst_mc encoding; 2'b11 also decodes as four machine cycles
    typedef enum logic [1:0] {
        MC_1 = 2'b00,
        MC_2 = 2'b01,
        MC_4 = 2'b10
    } mc_enc_e;

    typedef enum logic [1:0] {
        FETCH_OP,
        FETCH_B1,
        FETCH_B2,
        EXEC
    } seq_state_e;

    function automatic logic [1:0] len_eff(input logic [1:0] len);
        return (len == 2'd0) ? 2'd1 : len;
    endfunction

    // Index of the final machine cycle; three-byte opcodes need MC1 for their last byte.
    function automatic logic [1:0] last_mc_of(input logic [1:0] len, input logic [1:0] mc);
        logic [1:0] last;
        if (mc[1])
            last = 2'd3;
        else if (mc == MC_2)
            last = 2'd1;
        else
            last = 2'd0;
        if (len == 2'd3 && last == 2'd0)
            last = 2'd1;
        return last;
    endfunction

endpackage

// File: rtl/mcu51_cycle_sequencer_timing.sv
// Tick / machine-cycle counter with stall hold; exposes next-state values for registered decode.
module mc_timing_gen
    import mcu51_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic [1:0] last_mc,
    output logic [3:0] tick,
    output logic [1:0] mc_idx,
    output logic [3:0] tick_next,
    output logic [1:0] mc_next
);

    always_comb begin
        tick_next = tick;
        mc_next   = mc_idx;
        if (!stall) begin
            if (tick == T_LAST) begin
                tick_next = 4'd0;
                mc_next   = (mc_idx == last_mc) ? 2'd0 : mc_idx + 2'd1;
            end else begin
                tick_next = tick + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick   <= 4'd0;
            mc_idx <= 2'd0;
        end else begin
            tick   <= tick_next;
            mc_idx <= mc_next;
        end
    end

endmodule

// File: rtl/mcu51_cycle_sequencer.sv
// Fetch/execute sequencer: slot FSM plus strobe decode, all outputs registered from next-state values.
module mcu51_cycle_sequencer
    import mcu51_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] inst_len,
    input  logic [1:0] inst_mc,
    input  logic       jump_taken,
    input  logic       stall,
    output logic       ale,
    output logic       psen_n,
    output logic       code_cs,
    output logic       ir_en,
    output logic       b1_en,
    output logic       b2_en,
    output logic       pc_en,
    output logic       pc_load,
    output logic       wb_en,
    output logic [1:0] mc_idx,
    output logic [3:0] tick
);

    seq_state_e state, state_next;
    logic [1:0] len_q, last_mc, mc_next;
    logic [3:0] tick_next;
    logic       jump_q, jump_sel, last_next;
    logic       slot_a, slot_b, fetch_lat;
    logic       ale_d, psen_d, cs_d, ir_d, b1_d, b2_d, pc_d, ld_d, wb_d;

    mc_timing_gen u_timing (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .last_mc   (last_mc),
        .tick      (tick),
        .mc_idx    (mc_idx),
        .tick_next (tick_next),
        .mc_next   (mc_next)
    );

    // Operand-byte decision is made at tick 6 from the freshly decoded length.
    always_comb begin
        state_next = state;
        if (!stall) begin
            unique case (state)
                FETCH_OP: if (tick == T_LAT_A) state_next = FETCH_B1;
                FETCH_B1: begin
                    if (tick == T_SLOT_B && len_eff(inst_len) < 2'd2)
                        state_next = EXEC;
                    else if (tick == T_LAT_B)
                        state_next = (len_q == 2'd3) ? FETCH_B2 : EXEC;
                end
                FETCH_B2: if (tick == T_LAT_A) state_next = EXEC;
                EXEC:     state_next = EXEC;
            endcase
            if (tick == T_LAST && mc_idx == last_mc)
                state_next = FETCH_OP;
        end
    end

    always_comb begin
        slot_a    = (state_next == FETCH_OP) || (state_next == FETCH_B2);
        slot_b    = (state_next == FETCH_B1);
        last_next = (mc_next == last_mc);
        ale_d     = (tick_next >= T_ALE_A && tick_next <= T_ALE_A + 4'd1) ||
                    (tick_next >= T_ALE_B && tick_next <= T_ALE_B + 4'd1);
        psen_d    = (slot_a && tick_next >= T_PSEN_A && tick_next <= T_LAT_A) ||
                    (slot_b && tick_next >= T_PSEN_B && tick_next <= T_LAT_B);
        cs_d      = (slot_a && tick_next >= T_CS_A && tick_next <= T_LAT_A) ||
                    (slot_b && tick_next >= T_CS_B && tick_next <= T_LAT_B);
        fetch_lat = (slot_a && tick_next == T_LAT_A) || (slot_b && tick_next == T_LAT_B);
        ir_d      = fetch_lat && (state_next == FETCH_OP);
        b1_d      = fetch_lat && (state_next == FETCH_B1);
        b2_d      = fetch_lat && (state_next == FETCH_B2);
        wb_d      = (tick_next == T_WB) && last_next;
        // jump_q covers stalls between the wb_en clock and the tick-11 advance
        jump_sel  = wb_en ? jump_taken : jump_q;
        ld_d      = (tick_next == T_LAST) && last_next && jump_sel && !fetch_lat;
        pc_d      = fetch_lat || ld_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH_OP;
            len_q   <= 2'd1;
            last_mc <= 2'd0;
            jump_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == FETCH_B1 && tick == T_SLOT_B) begin
                len_q   <= len_eff(inst_len);
                last_mc <= last_mc_of(inst_len, inst_mc);
            end
            if (wb_en)
                jump_q <= jump_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || stall) begin
            ale     <= 1'b0;
            psen_n  <= 1'b1;
            code_cs <= 1'b0;
            ir_en   <= 1'b0;
            b1_en   <= 1'b0;
            b2_en   <= 1'b0;
            pc_en   <= 1'b0;
            pc_load <= 1'b0;
            wb_en   <= 1'b0;
        end else begin
            ale     <= ale_d;
            psen_n  <= !psen_d;
            code_cs <= cs_d;
            ir_en   <= ir_d;
            b1_en   <= b1_d;
            b2_en   <= b2_d;
            pc_en   <= pc_d;
            pc_load <= ld_d;
            wb_en   <= wb_d;
        end
    end

endmodule

// File: tb/tb_mcu51_cycle_sequencer.sv
// Scoreboard bench: expected strobe events are queued per scenario and popped as the DUT emits them.
module tb_mcu51_cycle_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] inst_len = 2'd1;
    logic [1:0] inst_mc = 2'd0;
    logic       jump_taken = 1'b0;
    logic       stall = 1'b0;
    logic       ale, psen_n, code_cs, ir_en, b1_en, b2_en, pc_en, pc_load, wb_en;
    logic [1:0] mc_idx;
    logic [3:0] tick;

    always #5 clk = ~clk;

    mcu51_cycle_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .inst_len   (inst_len),
        .inst_mc    (inst_mc),
        .jump_taken (jump_taken),
        .stall      (stall),
        .ale        (ale),
        .psen_n     (psen_n),
        .code_cs    (code_cs),
        .ir_en      (ir_en),
        .b1_en      (b1_en),
        .b2_en      (b2_en),
        .pc_en      (pc_en),
        .pc_load    (pc_load),
        .wb_en      (wb_en),
        .mc_idx     (mc_idx),
        .tick       (tick)
    );

    localparam logic [6:0] CS = 7'b0000001;
    localparam logic [6:0] WB = 7'b0000010;
    localparam logic [6:0] LD = 7'b0000100;
    localparam logic [6:0] PC = 7'b0001000;
    localparam logic [6:0] B2 = 7'b0010000;
    localparam logic [6:0] B1 = 7'b0100000;
    localparam logic [6:0] IR = 7'b1000000;

    typedef struct {
        int         cyc;
        logic [6:0] val;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [6:0] obs;
    logic [3:0] tick_log [0:63];
    logic [1:0] mc_log [0:63];
    logic [8:0] out_log [0:63];

    assign obs = {ir_en, b1_en, b2_en, pc_en, pc_load, wb_en, code_cs};

    task automatic push(input int cyc, input logic [6:0] val);
        ev_t e;
        e.cyc = cyc;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Leaves the bench #1 after the last reset edge, i.e. inside cycle t=0.
    task automatic do_reset(input logic [1:0] len, input logic [1:0] mc, input logic jmp);
        inst_len = len;
        inst_mc = mc;
        jump_taken = jmp;
        stall = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // s0..s1: cycles whose entering edge sees stall=1; rst_at: cycle during which reset is held.
    task automatic run(input int n, input int s0, input int s1, input int rst_at,
                       input int exp_psen, input int exp_ale, input string name);
        ev_t e;
        int psen_cnt = 0;
        int ale_cnt = 0;
        for (int c = 0; c < n; c++) begin
            stall = (c + 1 >= s0) && (c + 1 <= s1);
            reset = (c == rst_at);
            @(negedge clk);
            tick_log[c] = tick;
            mc_log[c] = mc_idx;
            out_log[c] = {ale, psen_n, obs};
            if (psen_n === 1'b0) psen_cnt++;
            if (ale === 1'b1) ale_cnt++;
            if (obs !== 7'd0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_strobe cyc=%0d got=%b", name, c, obs);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != c || e.val !== obs) begin
                        failures++;
                        $display("FAIL %s strobe got cyc=%0d val=%b want cyc=%0d val=%b",
                                 name, c, obs, e.cyc, e.val);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        reset = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_events got=%0d want=0 next_cyc=%0d", name, exp_q.size(),
                     exp_q[0].cyc);
        end
        checks++;
        if (psen_cnt != exp_psen) begin
            failures++;
            $display("FAIL %s psen_cycles got=%0d want=%0d", name, psen_cnt, exp_psen);
        end
        checks++;
        if (ale_cnt != exp_ale) begin
            failures++;
            $display("FAIL %s ale_cycles got=%0d want=%0d", name, ale_cnt, exp_ale);
        end
    endtask

    task automatic test_reset();
        inst_len = 2'd1;
        inst_mc = 2'd0;
        reset = 1'b1;
        stall = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ale, psen_n, obs, tick, mc_idx} !== {1'b0, 1'b1, 7'd0, 4'd0, 2'd0}) begin
            failures++;
            $display("FAIL reset_idle got ale=%b psen_n=%b strobes=%b tick=%0d mc=%0d want 0 1 0 0 0",
                     ale, psen_n, obs, tick, mc_idx);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (tick !== 4'd0 || ale !== 1'b0) begin
            failures++;
            $display("FAIL reset_t0 got tick=%0d ale=%b want tick=0 ale=0", tick, ale);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (tick !== 4'd1 || ale !== 1'b1) begin
            failures++;
            $display("FAIL reset_t1 got tick=%0d ale=%b want tick=1 ale=1", tick, ale);
        end
    endtask

    task automatic test_nop();
        do_reset(2'd1, 2'b00, 1'b0);
        push(4, CS); push(5, IR|PC|CS); push(10, WB);
        push(16, CS); push(17, IR|PC|CS); push(22, WB);
        run(24, -1, -1, -1, 6, 8, "nop");
        checks++;
        if (tick_log[13] !== 4'd1 || mc_log[13] !== 2'd0) begin
            failures++;
            $display("FAIL nop_wrap got tick=%0d mc=%0d want tick=1 mc=0", tick_log[13], mc_log[13]);
        end
    endtask

    task automatic test_mov();
        do_reset(2'd2, 2'b00, 1'b0);
        push(4, CS); push(5, IR|PC|CS); push(10, CS|WB); push(11, B1|PC|CS);
        push(16, CS); push(17, IR|PC|CS); push(22, CS|WB); push(23, B1|PC|CS);
        run(24, -1, -1, -1, 12, 8, "mov");
    endtask

    task automatic test_ljmp();
        do_reset(2'd3, 2'b01, 1'b1);
        push(4, CS); push(5, IR|PC|CS); push(10, CS); push(11, B1|PC|CS);
        push(16, CS); push(17, B2|PC|CS); push(22, WB); push(23, PC|LD);
        push(28, CS); push(29, IR|PC|CS);
        run(30, -1, -1, -1, 12, 10, "ljmp");
        checks++;
        if (mc_log[12] !== 2'd1 || mc_log[24] !== 2'd0) begin
            failures++;
            $display("FAIL ljmp_mc got mc12=%0d mc24=%0d want 1 0", mc_log[12], mc_log[24]);
        end
    endtask

    task automatic test_mul();
        do_reset(2'd1, 2'b10, 1'b0);
        push(4, CS); push(5, IR|PC|CS); push(46, WB); push(52, CS); push(53, IR|PC|CS);
        run(54, -1, -1, -1, 6, 18, "mul");
        checks++;
        if ({mc_log[12], mc_log[24], mc_log[36], mc_log[48]} !== 8'b01_10_11_00) begin
            failures++;
            $display("FAIL mul_mc got %0d %0d %0d %0d want 1 2 3 0",
                     mc_log[12], mc_log[24], mc_log[36], mc_log[48]);
        end
    endtask

    task automatic test_stall();
        do_reset(2'd1, 2'b00, 1'b0);
        push(7, CS); push(8, IR|PC|CS); push(13, WB); push(19, CS); push(20, IR|PC|CS);
        run(24, 4, 6, -1, 6, 8, "stall");
        checks++;
        if (tick_log[5] !== 4'd3 || out_log[5] !== {1'b0, 1'b1, 7'd0} || tick_log[8] !== 4'd5) begin
            failures++;
            $display("FAIL stall_hold got tick5=%0d out5=%b tick8=%0d want 3 010000000 5",
                     tick_log[5], out_log[5], tick_log[8]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2'd3, 2'b01, 1'b1);
        push(4, CS); push(5, IR|PC|CS); push(10, CS); push(11, B1|PC|CS);
        push(16, CS); push(17, B2|PC|CS); push(26, CS); push(27, IR|PC|CS);
        run(30, -1, -1, 21, 12, 11, "reset_mid");
        checks++;
        if (mc_log[21] !== 2'd1 || tick_log[22] !== 4'd0 || mc_log[22] !== 2'd0 ||
            out_log[22] !== {1'b0, 1'b1, 7'd0}) begin
            failures++;
            $display("FAIL reset_mid_idle got mc21=%0d tick22=%0d mc22=%0d out22=%b want 1 0 0 010000000",
                     mc_log[21], tick_log[22], mc_log[22], out_log[22]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(2'd2, 2'b01, 1'b1);
        push(4, CS); push(5, IR|PC|CS); push(10, CS); push(11, B1|PC|CS);
        push(22, WB); push(23, PC|LD);
        push(28, CS); push(29, IR|PC|CS); push(34, CS); push(35, B1|PC|CS);
        run(36, -1, -1, -1, 12, 12, "back_to_back");
    endtask

    task automatic test_len0();
        do_reset(2'd0, 2'b00, 1'b0);
        push(4, CS); push(5, IR|PC|CS); push(10, WB); push(16, CS); push(17, IR|PC|CS);
        run(18, -1, -1, -1, 6, 6, "len0");
    endtask

    initial begin
        test_reset();
        test_nop();
        test_mov();
        test_ljmp();
        test_mul();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_len0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
